// File: rtl/recon_mb_writer_pkg.sv
// Shared constants, state encoding and cache layout helper for recon_mb_writer.
package recon_mb_writer_pkg;

   localparam int MBS_CACHE      = 4;
   localparam int LOG2_MBS_CACHE = 2;
   localparam int MB_WORDS       = 96;
   localparam int EXT_ADDR_W     = 24;
   localparam int MB_IDX_W       = 14;

   localparam int CACHE_DEPTH = MBS_CACHE * MB_WORDS;
   localparam int CACHE_AW    = $clog2(CACHE_DEPTH);
   localparam int WORD_W      = $clog2(MB_WORDS);

   // Word offsets of the three planes inside one cached macroblock.
   localparam logic [WORD_W-1:0] LUMA_BASE = 7'd0;
   localparam logic [WORD_W-1:0] CB_BASE   = 7'd64;
   localparam logic [WORD_W-1:0] CR_BASE   = 7'd80;

   // Last 4x4 block of a macroblock (final Cr block).
   localparam logic [4:0] LAST_BLK = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_FLUSH_RD,
      ST_FLUSH_TX
   } state_t;

   // Word offset within a macroblock for row 'row' of 4x4 block 'blk'.
   // Luma rows are 4 words wide (16 pixels), chroma rows 2 words (8 pixels).
   function automatic logic [WORD_W-1:0] blk_row_offset(input logic [4:0] blk,
                                                        input logic [1:0] row);
      logic [WORD_W-1:0] off;
      if (blk < 5'd16) begin
         // y4 = {b3,b1}, x4 = {b2,b0}; offset = (y4*4 + row)*4 + x4
         off = LUMA_BASE + {1'b0, blk[3], blk[1], row, blk[2], blk[0]};
      end else begin
         // c = blk-16 only changes bit 4, so c[2:0] == blk[2:0]
         off = (blk[2] ? CR_BASE : CB_BASE) + {3'b000, blk[1], row, blk[0]};
      end
      return off;
   endfunction

endpackage

// File: rtl/recon_mb_cache_ram.sv
// Simple dual-port macroblock cache: synchronous write, registered read.
module recon_mb_cache_ram
   import recon_mb_writer_pkg::*;
#(
   parameter int DEPTH = CACHE_DEPTH,
   parameter int AW    = CACHE_AW,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:DEPTH-1];

   // Array write port.
   // NOTE: the storage array has no reset so it maps onto block RAM; its contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Registered read port; output register is reset so the bus reads 0 after reset.
   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rd_data <= '0;
      else if (re) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/recon_mb_writer.sv
// recon_mb_writer: captures reconstructed 4x4 blocks into a macroblock cache
// and bursts full (or end-of-frame partial) cache contents to frame memory.
// Optional statistics counters: define RECON_MB_WRITER_STATS_EN.
module recon_mb_writer
   import recon_mb_writer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write_to_ram_start,
   input  logic                  write_to_ext_ram_last_mb_start,
   input  logic [4:0]            blk4x4_counter,
   input  logic [MB_IDX_W-1:0]   mb_index,
   input  logic [127:0]          pix,
   output logic                  write_to_ram_idle,
`ifdef RECON_MB_WRITER_STATS_EN
   input  logic                  stat_clr,
   output logic [31:0]           stat_blk_cnt,
   output logic [15:0]           stat_flush_cnt,
`endif
   output logic                  ext_wr_valid,
   output logic [EXT_ADDR_W-1:0] ext_wr_addr,
   output logic [31:0]           ext_wr_data,
   input  logic                  ext_wr_ack,
   output logic                  flush_done
);

   state_t state_q, state_d;

   logic [4:0]                blk_q;
   logic [MB_IDX_W-1:0]       mb_q;
   logic [127:0]              pix_q;
   logic [1:0]                row_q;
   logic [LOG2_MBS_CACHE-1:0] fslot_q;
   logic [WORD_W-1:0]         fword_q;
   logic [EXT_ADDR_W-1:0]     addr_q;
   logic                      pend_q;
   logic                      done_q;

   logic                      cache_we, cache_re;
   logic [CACHE_AW-1:0]       cache_wr_addr, cache_rd_addr;
   logic [31:0]               cache_rd_data;
   logic [LOG2_MBS_CACHE-1:0] slot;
   logic [MB_IDX_W-1:0]       flush_base;
   logic [EXT_ADDR_W-1:0]     ext_addr_calc;
   logic                      last_word, last_row, cache_full, tx_last_ack;

   assign slot       = mb_q[LOG2_MBS_CACHE-1:0];
   assign flush_base = {mb_q[MB_IDX_W-1:LOG2_MBS_CACHE], {LOG2_MBS_CACHE{1'b0}}};
   assign last_row   = (row_q == 2'd3);
   assign cache_full = (blk_q == LAST_BLK) && (slot == LOG2_MBS_CACHE'(MBS_CACHE - 1));
   assign last_word  = (fword_q == WORD_W'(MB_WORDS - 1)) && (fslot_q == slot);
   assign tx_last_ack = (state_q == ST_FLUSH_TX) && ext_wr_ack && last_word;

   assign cache_wr_addr = CACHE_AW'(slot) * CACHE_AW'(MB_WORDS)
                        + CACHE_AW'(blk_row_offset(blk_q, row_q));
   assign cache_rd_addr = CACHE_AW'(fslot_q) * CACHE_AW'(MB_WORDS) + CACHE_AW'(fword_q);
   assign ext_addr_calc = (EXT_ADDR_W'(flush_base) + EXT_ADDR_W'(fslot_q)) * EXT_ADDR_W'(MB_WORDS)
                        + EXT_ADDR_W'(fword_q);

   assign ext_wr_addr = addr_q;
   assign ext_wr_data = cache_rd_data;
   assign flush_done  = done_q;

   recon_mb_cache_ram u_cache (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (cache_we),
      .wr_addr (cache_wr_addr),
      .wr_data (pix_q[{row_q, 5'b00000} +: 32]),
      .re      (cache_re),
      .rd_addr (cache_rd_addr),
      .rd_data (cache_rd_data)
   );

   // State register; reset abandons any flush and drops ext_wr_valid immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (write_to_ram_start) state_d = ST_WRITE;
            else if (pend_q)        state_d = ST_FLUSH_RD;
         end
         ST_WRITE: begin
            if (last_row) state_d = (cache_full || pend_q) ? ST_FLUSH_RD : ST_IDLE;
         end
         ST_FLUSH_RD: state_d = ST_FLUSH_TX;
         ST_FLUSH_TX: begin
            if (ext_wr_ack) state_d = last_word ? ST_IDLE : ST_FLUSH_RD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs and cache port strobes.
   always_comb begin
      write_to_ram_idle = (state_q == ST_IDLE) && !pend_q;
      ext_wr_valid      = (state_q == ST_FLUSH_TX);
      cache_we          = (state_q == ST_WRITE);
      cache_re          = (state_q == ST_FLUSH_RD);
   end

   // Block capture and row sequencing for the cache write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q <= '0;
         mb_q  <= '0;
         pix_q <= '0;
         row_q <= '0;
      end else if (state_q == ST_IDLE && write_to_ram_start) begin
         blk_q <= blk4x4_counter;
         mb_q  <= mb_index;
         pix_q <= pix;
         row_q <= '0;
      end else if (state_q == ST_WRITE) begin
         row_q <= row_q + 2'd1;
      end
   end

   // Flush request flag: a request arriving during a flush merges into it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              pend_q <= 1'b0;
      else if (tx_last_ack)                    pend_q <= 1'b0;
      else if (write_to_ext_ram_last_mb_start) pend_q <= 1'b1;
   end

   // Flush word/slot counters, external address register and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fslot_q <= '0;
         fword_q <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= tx_last_ack;
         if (state_q == ST_FLUSH_RD) addr_q <= ext_addr_calc;
         if (state_q == ST_FLUSH_TX && ext_wr_ack) begin
            if (last_word) begin
               fslot_q <= '0;
               fword_q <= '0;
            end else if (fword_q == WORD_W'(MB_WORDS - 1)) begin
               fword_q <= '0;
               fslot_q <= fslot_q + 1'b1;
            end else begin
               fword_q <= fword_q + 1'b1;
            end
         end
      end
   end

`ifdef RECON_MB_WRITER_STATS_EN
   // Wrapping activity counters; a clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_blk_cnt   <= '0;
         stat_flush_cnt <= '0;
      end else if (stat_clr) begin
         stat_blk_cnt   <= '0;
         stat_flush_cnt <= '0;
      end else begin
         if (state_q == ST_WRITE && last_row) stat_blk_cnt   <= stat_blk_cnt + 32'd1;
         if (tx_last_ack)                     stat_flush_cnt <= stat_flush_cnt + 16'd1;
      end
   end
`endif

   // Starting a block while busy is ignored by the FSM and flagged in simulation.
   assert property (@(posedge clk) disable iff (!rst_n)
                    write_to_ram_start |-> (state_q == ST_IDLE))
      else $error("recon_mb_writer: write_to_ram_start while not idle");

endmodule

// File: tb/tb_recon_mb_writer.sv
// Directed testbench for recon_mb_writer (default build, statistics disabled).
module tb_recon_mb_writer;
   import recon_mb_writer_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  write_to_ram_start;
   logic                  write_to_ext_ram_last_mb_start;
   logic [4:0]            blk4x4_counter;
   logic [MB_IDX_W-1:0]   mb_index;
   logic [127:0]          pix;
   logic                  write_to_ram_idle;
   logic                  ext_wr_valid;
   logic [EXT_ADDR_W-1:0] ext_wr_addr;
   logic [31:0]           ext_wr_data;
   logic                  ext_wr_ack;
   logic                  flush_done;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int cyc = 0;
   int          q_addr[$];
   logic [31:0] q_data[$];
   int          q_cyc[$];

   always #5 clk = ~clk;

   recon_mb_writer dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .write_to_ram_start             (write_to_ram_start),
      .write_to_ext_ram_last_mb_start (write_to_ext_ram_last_mb_start),
      .blk4x4_counter                 (blk4x4_counter),
      .mb_index                       (mb_index),
      .pix                            (pix),
      .write_to_ram_idle              (write_to_ram_idle),
      .ext_wr_valid                   (ext_wr_valid),
      .ext_wr_addr                    (ext_wr_addr),
      .ext_wr_data                    (ext_wr_data),
      .ext_wr_ack                     (ext_wr_ack),
      .flush_done                     (flush_done)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted external word and every flush_done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ext_wr_valid && ext_wr_ack) begin
            q_addr.push_back(int'(ext_wr_addr));
            q_data.push_back(ext_wr_data);
            q_cyc.push_back(cyc);
         end
         if (flush_done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] seq_pix(input int base);
      logic [127:0] p;
      for (int k = 0; k < 16; k++) p[8*k +: 8] = 8'(base + k);
      return p;
   endfunction

   // Row r of block b in frame MB m carries the word {A5, r, b, m}.
   function automatic logic [127:0] frame_pix(input int m, input int b);
      logic [127:0] p;
      for (int r = 0; r < 4; r++) p[32*r +: 32] = {8'hA5, 8'(r), 8'(b), 8'(m)};
      return p;
   endfunction

   // Expected data at external word address a, found by mapping the word
   // position in the MB back to its block and row.
   function automatic logic [31:0] exp_word(input int a);
      int m, w, yy, xx, y4, r, b, v;
      m = a / 96;
      w = a % 96;
      if (w < 64) begin
         yy = w / 4; xx = w % 4; y4 = yy / 4; r = yy % 4;
         b  = (y4 / 2) * 8 + (xx / 2) * 4 + (y4 % 2) * 2 + (xx % 2);
      end else begin
         v  = (w - 64) % 16; yy = v / 2; xx = v % 2; r = yy % 4;
         b  = 16 + ((w - 64) / 16) * 4 + (yy / 4) * 2 + xx;
      end
      return {8'hA5, 8'(r), 8'(b), 8'(m)};
   endfunction

   task automatic write_block(input int b, input int m, input logic [127:0] p);
      blk4x4_counter     = 5'(b);
      mb_index           = MB_IDX_W'(m);
      pix                = p;
      write_to_ram_start = 1'b1;
      step();
      write_to_ram_start = 1'b0;
      for (int i = 0; i < 20 && !write_to_ram_idle; i++) step();
      total++;
      if (write_to_ram_idle !== 1'b1) begin
         bad++;
         $display("FAIL write_idle_timeout blk=%0d mb=%0d got idle=%b want 1", b, m, write_to_ram_idle);
      end
   endtask

   task automatic test_reset();
      total++; if (write_to_ram_idle !== 1'b1) begin bad++; $display("FAIL rst_idle got %b want 1", write_to_ram_idle); end
      total++; if (ext_wr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", ext_wr_valid); end
      total++; if (ext_wr_addr !== '0) begin bad++; $display("FAIL rst_addr got %h want 0", ext_wr_addr); end
      total++; if (ext_wr_data !== '0) begin bad++; $display("FAIL rst_data got %h want 0", ext_wr_data); end
      total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", flush_done); end
   endtask

   task automatic test_luma();
      logic [31:0] want [4];
      int          addr [4];
      want = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      addr = '{99, 103, 107, 111};
      blk4x4_counter     = 5'd5;
      mb_index           = MB_IDX_W'(1);
      pix                = seq_pix(0);
      write_to_ram_start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         write_to_ram_start = 1'b0;
         total++;
         if (write_to_ram_idle !== (i == 5)) begin
            bad++;
            $display("FAIL luma_idle cycle=%0d got %b want %b", i, write_to_ram_idle, (i == 5));
         end
      end
      for (int r = 0; r < 4; r++) begin
         total++;
         if (dut.u_cache.mem[addr[r]] !== want[r]) begin
            bad++;
            $display("FAIL luma_word addr=%0d got %h want %h", addr[r], dut.u_cache.mem[addr[r]], want[r]);
         end
      end
   endtask

   task automatic test_chroma();
      logic [127:0] p;
      p = seq_pix(16);
      write_block(22, 0, p);
      for (int r = 0; r < 4; r++) begin
         total++;
         if (dut.u_cache.mem[88 + 2*r] !== p[32*r +: 32]) begin
            bad++;
            $display("FAIL chroma_word addr=%0d got %h want %h", 88 + 2*r, dut.u_cache.mem[88 + 2*r], p[32*r +: 32]);
         end
      end
   endtask

   // Compare the recorded words against base..base+n-1 with expected data.
   task automatic check_burst(input string name, input int base, input int n);
      int nerr = 0;
      int first = -1;
      total++;
      if (q_addr.size() != n) begin
         bad++;
         $display("FAIL %s_count got %0d want %0d", name, q_addr.size(), n);
      end
      for (int i = 0; i < q_addr.size(); i++) begin
         if (q_addr[i] != base + i || q_data[i] !== exp_word(base + i)) begin
            nerr++;
            if (first < 0) first = i;
         end
      end
      total++;
      if (nerr != 0) begin
         bad++;
         $display("FAIL %s_words bad=%0d first idx=%0d got addr=%0d data=%h want addr=%0d data=%h",
                  name, nerr, first, q_addr[first], q_data[first], base + first, exp_word(base + first));
      end
   endtask

   task automatic test_full_cache();
      int d0 = done_cnt;
      int span;
      ext_wr_ack = 1'b1;
      q_addr.delete(); q_data.delete(); q_cyc.delete();
      for (int m = 0; m < 4; m++)
         for (int b = 0; b < 24; b++)
            if (!(m == 3 && b == 23)) write_block(b, m, frame_pix(m, b));
      total++;
      if (q_addr.size() != 0 || done_cnt != d0) begin
         bad++;
         $display("FAIL full_early_flush got words=%0d dones=%0d want 0 0", q_addr.size(), done_cnt - d0);
      end
      blk4x4_counter     = 5'd23;
      mb_index           = MB_IDX_W'(3);
      pix                = frame_pix(3, 23);
      write_to_ram_start = 1'b1;
      step();
      write_to_ram_start = 1'b0;
      for (int i = 0; i < 2000 && done_cnt == d0; i++) step();
      repeat (10) step();
      total++;
      if (done_cnt != d0 + 1) begin
         bad++;
         $display("FAIL full_done got %0d pulses want 1", done_cnt - d0);
      end
      check_burst("full", 0, 384);
      span = (q_cyc.size() == 384) ? q_cyc[383] - q_cyc[0] : -1;
      total++;
      if (span != 766) begin
         bad++;
         $display("FAIL full_rate got span=%0d want 766", span);
      end
   endtask

   task automatic test_last_mb();
      int d0 = done_cnt;
      int n0;
      int stall_err = 0;
      logic [EXT_ADDR_W-1:0] a_snap;
      logic [31:0]           d_snap;
      ext_wr_ack = 1'b1;
      q_addr.delete(); q_data.delete(); q_cyc.delete();
      for (int m = 4; m < 6; m++)
         for (int b = 0; b < 24; b++) write_block(b, m, frame_pix(m, b));
      total++;
      if (q_addr.size() != 0 || done_cnt != d0) begin
         bad++;
         $display("FAIL last_early_flush got words=%0d dones=%0d want 0 0", q_addr.size(), done_cnt - d0);
      end
      write_to_ext_ram_last_mb_start = 1'b1;
      step();
      write_to_ext_ram_last_mb_start = 1'b0;
      total++;
      if (write_to_ram_idle !== 1'b0) begin
         bad++;
         $display("FAIL last_idle_low got %b want 0", write_to_ram_idle);
      end
      for (int i = 0; i < 500 && q_addr.size() < 50; i++) step();
      // Stall the bus and fire a second flush request, which must merge.
      ext_wr_ack = 1'b0;
      write_to_ext_ram_last_mb_start = 1'b1;
      step();
      write_to_ext_ram_last_mb_start = 1'b0;
      for (int i = 0; i < 5 && !ext_wr_valid; i++) step();
      a_snap = ext_wr_addr;
      d_snap = ext_wr_data;
      n0     = q_addr.size();
      for (int i = 0; i < 10; i++) begin
         step();
         if (ext_wr_valid !== 1'b1 || ext_wr_addr !== a_snap || ext_wr_data !== d_snap) stall_err++;
      end
      total++;
      if (stall_err != 0 || q_addr.size() != n0 || n0 < 50) begin
         bad++;
         $display("FAIL last_stall got errs=%0d words=%0d->%0d want 0 errs, no new words", stall_err, n0, q_addr.size());
      end
      ext_wr_ack = 1'b1;
      for (int i = 0; i < 1000 && done_cnt == d0; i++) step();
      repeat (20) step();
      total++;
      if (done_cnt != d0 + 1) begin
         bad++;
         $display("FAIL last_done got %0d pulses want 1", done_cnt - d0);
      end
      check_burst("last", 384, 192);
      total++;
      if (write_to_ram_idle !== 1'b1 || ext_wr_valid !== 1'b0) begin
         bad++;
         $display("FAIL last_end got idle=%b valid=%b want 1 0", write_to_ram_idle, ext_wr_valid);
      end
   endtask

   task automatic test_reset_mid_flush();
      logic [127:0] p;
      int d0;
      ext_wr_ack = 1'b0;
      write_to_ext_ram_last_mb_start = 1'b1;
      step();
      write_to_ext_ram_last_mb_start = 1'b0;
      for (int i = 0; i < 10 && !ext_wr_valid; i++) step();
      total++;
      if (ext_wr_valid !== 1'b1) begin
         bad++;
         $display("FAIL rmf_valid_before got %b want 1", ext_wr_valid);
      end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ext_wr_valid !== 1'b0 || write_to_ram_idle !== 1'b1 || ext_wr_addr !== '0) begin
         bad++;
         $display("FAIL rmf_async got valid=%b idle=%b addr=%h want 0 1 0", ext_wr_valid, write_to_ram_idle, ext_wr_addr);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      ext_wr_ack = 1'b1;
      q_addr.delete(); q_data.delete(); q_cyc.delete();
      d0 = done_cnt;
      p  = seq_pix(8'h40);
      write_block(0, 2, p);
      for (int r = 0; r < 4; r++) begin
         total++;
         if (dut.u_cache.mem[192 + 4*r] !== p[32*r +: 32]) begin
            bad++;
            $display("FAIL rmf_word addr=%0d got %h want %h", 192 + 4*r, dut.u_cache.mem[192 + 4*r], p[32*r +: 32]);
         end
      end
      repeat (20) step();
      total++;
      if (q_addr.size() != 0 || done_cnt != d0) begin
         bad++;
         $display("FAIL rmf_no_flush got words=%0d dones=%0d want 0 0", q_addr.size(), done_cnt - d0);
      end
   endtask

   initial begin
      rst_n                          = 1'b0;
      write_to_ram_start             = 1'b0;
      write_to_ext_ram_last_mb_start = 1'b0;
      blk4x4_counter                 = '0;
      mb_index                       = '0;
      pix                            = '0;
      ext_wr_ack                     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      test_reset();
      test_luma();
      test_chroma();
      test_full_cache();
      test_last_mb();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
